// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared select/state encodings and default vectors for the PC sequencer
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_SEQ    = 3'd0,
      SEL_BRANCH = 3'd1,
      SEL_JUMP   = 3'd2,
      SEL_CALL   = 3'd3,
      SEL_RET    = 3'd4,
      SEL_ERET   = 3'd5
   } pc_sel_e;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_ISR = 1'b1
   } pc_state_e;

   localparam int          DEF_STEP         = 4;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_IRQ_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating occupancy count
module pc_ras #(
   parameter int RAS_DEPTH  = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [ADDR_WIDTH-1:0]        i_push_data,
   output logic [ADDR_WIDTH-1:0]        o_top,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(RAS_DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [ADDR_WIDTH-1:0] r_mem [RAS_DEPTH];
   logic [PTR_W-1:0]      r_ptr;
   logic [PTR_W:0]        r_count;
   logic [PTR_W-1:0]      w_top_idx;

   // r_ptr is the next write slot; the top entry sits one below it
   assign w_top_idx = r_ptr - PTR_W'(1);
   assign o_top     = r_mem[w_top_idx];
   assign o_full    = (r_count == (PTR_W+1)'(RAS_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

   always_ff @(posedge i_clock) begin
      if (i_push) begin
         r_mem[r_ptr] <= i_push_data;
      end
   end

   // A push on a full stack wraps over the oldest entry and leaves the count saturated
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (i_push) begin
         r_ptr <= r_ptr + PTR_W'(1);
         if (!o_full) begin
            r_count <= r_count + (PTR_W+1)'(1);
         end
      end else if (i_pop && !o_empty) begin
         r_ptr   <= r_ptr - PTR_W'(1);
         r_count <= r_count - (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with RAS call/return, single-level interrupt and EPC
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    STEP         = DEF_STEP,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
   parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = ADDR_WIDTH'(DEF_IRQ_VECTOR),
   parameter int                    RAS_DEPTH    = 4
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         i_halt,
   input  logic [2:0]                   i_pc_sel,
   input  logic                         i_branch_taken,
   input  logic [ADDR_WIDTH-1:0]        i_target,
   input  logic                         i_irq,
   output logic [ADDR_WIDTH-1:0]        o_current_pc,
   output logic [ADDR_WIDTH-1:0]        o_epc,
   output logic                         o_in_isr,
   output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
   output logic                         o_ras_overflow,
   output logic                         o_ras_underflow
);

   pc_state_e             r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
   logic [ADDR_WIDTH-1:0] r_epc, w_epc_next;
   logic                  r_ovf, r_unf;
   logic                  w_set_ovf, w_set_unf;
   logic                  w_push, w_pop;
   logic [ADDR_WIDTH-1:0] w_seq_pc;
   logic [ADDR_WIDTH-1:0] w_ras_top;
   logic                  w_ras_full, w_ras_empty;

   assign w_seq_pc = r_pc + ADDR_WIDTH'(STEP);

   pc_ras #(
      .RAS_DEPTH  (RAS_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ras (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_data (w_seq_pc),
      .o_top       (w_ras_top),
      .o_full      (w_ras_full),
      .o_empty     (w_ras_empty),
      .o_count     (o_ras_count)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_VECTOR;
         r_epc   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_epc   <= w_epc_next;
         r_ovf   <= r_ovf | w_set_ovf;
         r_unf   <= r_unf | w_set_unf;
      end
   end

   // Halt leaves every default in place, so nothing moves and the RAS sees no push/pop
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_epc_next   = r_epc;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_set_ovf    = 1'b0;
      w_set_unf    = 1'b0;
      if (!i_halt) begin
         if (i_irq && (r_state == ST_RUN)) begin
            w_epc_next   = r_pc;
            w_pc_next    = IRQ_VECTOR;
            w_state_next = ST_ISR;
         end else begin
            case (i_pc_sel)
               SEL_BRANCH: w_pc_next = i_branch_taken ? i_target : w_seq_pc;
               SEL_JUMP:   w_pc_next = i_target;
               SEL_CALL: begin
                  w_push    = 1'b1;
                  w_pc_next = i_target;
                  w_set_ovf = w_ras_full;
               end
               SEL_RET: begin
                  if (w_ras_empty) begin
                     w_pc_next = w_seq_pc;
                     w_set_unf = 1'b1;
                  end else begin
                     w_pop     = 1'b1;
                     w_pc_next = w_ras_top;
                  end
               end
               SEL_ERET: begin
                  if (r_state == ST_ISR) begin
                     w_pc_next    = r_epc;
                     w_state_next = ST_RUN;
                  end else begin
                     w_pc_next = w_seq_pc;
                  end
               end
               default:    w_pc_next = w_seq_pc;
            endcase
         end
      end
   end

   assign o_current_pc    = r_pc;
   assign o_epc           = r_epc;
   assign o_in_isr        = (r_state == ST_ISR);
   assign o_ras_overflow  = r_ovf;
   assign o_ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with default parameters
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset, halt, branch_taken, irq;
   logic [2:0]  pc_sel;
   logic [31:0] target;
   logic [31:0] current_pc, epc;
   logic        in_isr, ras_overflow, ras_underflow;
   logic [2:0]  ras_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4, ERET = 3'd5;

   always #5 clock = ~clock;

   pc_sequencer dut (
      .i_clock         (clock),
      .i_reset         (reset),
      .i_halt          (halt),
      .i_pc_sel        (pc_sel),
      .i_branch_taken  (branch_taken),
      .i_target        (target),
      .i_irq           (irq),
      .o_current_pc    (current_pc),
      .o_epc           (epc),
      .o_in_isr        (in_isr),
      .o_ras_count     (ras_count),
      .o_ras_overflow  (ras_overflow),
      .o_ras_underflow (ras_underflow)
   );

   // Drive one cycle, queue the expected PC, then pop and compare after the edge
   task automatic cycle(input logic rst, input logic hlt, input logic irq_in,
                        input logic [2:0] sel, input logic tkn, input logic [31:0] tgt,
                        input logic [31:0] exp_pc, input string name);
      logic [31:0] e;
      reset = rst; halt = hlt; irq = irq_in; pc_sel = sel; branch_taken = tkn; target = tgt;
      exp_q.push_back(exp_pc);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (current_pc !== e) begin
         errors++;
         $display("FAIL %s pc got %h expected %h", name, current_pc, e);
      end
   endtask

   task automatic chk_state(input string name, input logic [31:0] exp_epc, input logic exp_isr,
                            input logic [2:0] exp_cnt, input logic exp_ovf, input logic exp_unf);
      checks++;
      if (epc !== exp_epc || in_isr !== exp_isr || ras_count !== exp_cnt ||
          ras_overflow !== exp_ovf || ras_underflow !== exp_unf) begin
         errors++;
         $display("FAIL %s got epc=%h isr=%b cnt=%0d ovf=%b unf=%b expected epc=%h isr=%b cnt=%0d ovf=%b unf=%b",
                  name, epc, in_isr, ras_count, ras_overflow, ras_underflow,
                  exp_epc, exp_isr, exp_cnt, exp_ovf, exp_unf);
      end
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, SEQ, 0, 0, 32'h0, "reset");
      chk_state("reset_state", 32'h0, 0, 3'd0, 0, 0);
   endtask

   task automatic test_seq_halt();
      cycle(0, 0, 0, SEQ, 0, 0, 32'h4, "seq1");
      cycle(0, 0, 0, SEQ, 0, 0, 32'h8, "seq2");
      cycle(0, 0, 0, SEQ, 0, 0, 32'hC, "seq3");
      cycle(0, 1, 0, JMP, 0, 32'h500, 32'hC, "halt1");
      cycle(0, 1, 0, SEQ, 0, 0, 32'hC, "halt2");
      cycle(0, 0, 0, SEQ, 0, 0, 32'h10, "seq_after_halt");
   endtask

   task automatic test_branch_jump();
      cycle(0, 0, 0, BR, 0, 32'h200, 32'h14, "branch_not_taken");
      cycle(0, 0, 0, BR, 1, 32'h200, 32'h200, "branch_taken");
      cycle(0, 0, 0, JMP, 0, 32'h300, 32'h300, "jump");
   endtask

   task automatic test_call_return();
      for (int i = 1; i <= 5; i++) begin
         cycle(0, 0, 0, CALL, 0, 32'(i) << 12, 32'(i) << 12, "call");
         if (i == 4) chk_state("call_full", 32'h0, 0, 3'd4, 0, 0);
      end
      chk_state("call_overflow", 32'h0, 0, 3'd4, 1, 0);
      for (int i = 4; i >= 1; i--) begin
         cycle(0, 0, 0, RET, 0, 0, (32'(i) << 12) + 32'h4, "ret");
         chk_state("ret_count", 32'h0, 0, 3'(i - 1), 1, 0);
      end
      cycle(0, 0, 0, RET, 0, 0, 32'h1008, "ret_empty");
      chk_state("ret_underflow", 32'h0, 0, 3'd0, 1, 1);
   endtask

   task automatic test_irq();
      cycle(0, 0, 0, JMP, 0, 32'h40, 32'h40, "jump_to_40");
      cycle(0, 1, 1, SEQ, 0, 0, 32'h40, "irq_during_halt");
      chk_state("irq_halt_state", 32'h0, 0, 3'd0, 1, 1);
      cycle(0, 0, 1, JMP, 0, 32'h999, 32'h80, "irq_entry");
      chk_state("irq_entry_state", 32'h40, 1, 3'd0, 1, 1);
      cycle(0, 0, 1, SEQ, 0, 0, 32'h84, "isr_seq1");
      cycle(0, 0, 1, SEQ, 0, 0, 32'h88, "isr_seq2");
      chk_state("isr_no_nest", 32'h40, 1, 3'd0, 1, 1);
      cycle(0, 0, 1, ERET, 0, 0, 32'h40, "eret");
      chk_state("eret_state", 32'h40, 0, 3'd0, 1, 1);
      cycle(0, 0, 1, SEQ, 0, 0, 32'h80, "irq_reentry");
      chk_state("reentry_state", 32'h40, 1, 3'd0, 1, 1);
      cycle(0, 0, 0, ERET, 0, 0, 32'h40, "eret2");
   endtask

   task automatic test_wrap();
      cycle(1, 0, 0, SEQ, 0, 0, 32'h0, "wrap_reset");
      cycle(0, 0, 0, ERET, 0, 0, 32'h4, "eret_in_run");
      cycle(0, 0, 0, 3'd7, 0, 32'h700, 32'h8, "sel7_is_seq");
      cycle(0, 0, 0, JMP, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "jump_top");
      cycle(0, 0, 0, SEQ, 0, 0, 32'h0, "wrap");
      chk_state("wrap_flags", 32'h0, 0, 3'd0, 0, 0);
   endtask

   task automatic test_reset_mid_isr();
      cycle(0, 0, 0, RET, 0, 0, 32'h4, "ret_empty2");
      for (int i = 1; i <= 5; i++) begin
         cycle(0, 0, 0, CALL, 0, 32'(i) << 8, 32'(i) << 8, "call2");
      end
      cycle(0, 0, 0, RET, 0, 0, 32'h404, "ret_a");
      cycle(0, 0, 0, RET, 0, 0, 32'h304, "ret_b");
      cycle(0, 0, 1, RET, 0, 0, 32'h80, "irq_entry2");
      chk_state("pre_reset_state", 32'h304, 1, 3'd2, 1, 1);
      cycle(1, 0, 1, SEQ, 0, 0, 32'h0, "reset_mid_isr");
      chk_state("post_reset_state", 32'h0, 0, 3'd0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_seq_halt();
      test_branch_jump();
      test_call_return();
      test_irq();
      test_wrap();
      test_reset_mid_isr();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the next-generation core. It replaces the plain reset/halt/load PC register. It computes the next fetch address internally from a control select and adds:
- a circular return-address stack (RAS) for call/return,
- single-level interrupt entry/exit with a saved exception PC (EPC),
- sticky stack-error flags.

It sits between the control unit (select, target, branch outcome) and instruction memory (current PC).

## Interface
Parameters:
- ADDR_WIDTH, 32: width of all addresses.
- STEP, 4: sequential increment in bytes.
- RESET_VECTOR, 0: PC value after reset.
- IRQ_VECTOR, 32'h80: interrupt handler address.
- RAS_DEPTH, 4: RAS entries, power of two, ≥2.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  when 1, holds every register (PC, EPC, RAS, state, flags).
- pc_sel  in  3  operation select:
  - 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 ERET.
  - Codes 6–7 are treated as SEQ.
- branch_taken  in  1  BRANCH outcome.
- target  in  ADDR_WIDTH  BRANCH/JUMP/CALL destination.
- irq  in  1  level-sensitive interrupt request.
- current_pc  out  ADDR_WIDTH  registered fetch address.
- epc  out  ADDR_WIDTH  saved interrupt return address.
- in_isr  out  1  1 while servicing an interrupt.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky flag: CALL pushed onto a full RAS.
- ras_underflow  out  1  sticky flag: RET issued with an empty RAS.

## Operation
- **State machine:**
  - RUN → ISR on an accepted irq.
  - ISR → RUN on ERET.
  - No other transitions.
- **Per-edge priority:** reset > halt > irq entry > pc_sel.
- **Reset:**
  - current_pc=RESET_VECTOR, epc=0, state RUN (in_isr=0).
  - RAS emptied (ras_count=0); both sticky flags cleared.
- **halt=1:** nothing changes, including flags. An irq arriving during halt is not latched.
- **irq entry** (irq=1, state RUN, halt=0):
  - epc ← current_pc; current_pc ← IRQ_VECTOR; state → ISR.
  - pc_sel that cycle is discarded and the RAS is untouched.
  - The preempted instruction is re-fetched after ERET.
- **irq in ISR:** ignored. No nesting and no internal pending latch; the source must hold the level.
- **SEQ:** current_pc ← current_pc+STEP.
- **BRANCH:** current_pc ← target if branch_taken, else current_pc+STEP.
- **JUMP:** current_pc ← target.
- **CALL:** push current_pc+STEP; current_pc ← target.
  - When the RAS is full, the oldest entry is overwritten (circular).
  - ras_count saturates at RAS_DEPTH and ras_overflow is set.
- **RET:** current_pc ← top of RAS (pop); ras_count decrements.
  - When the RAS is empty: current_pc ← current_pc+STEP, ras_underflow is set, and the pointer is unchanged.
- **ERET in ISR:** current_pc ← epc; state → RUN. epc keeps its value.
- **ERET in RUN:** treated as SEQ.
- **Arithmetic:** all address arithmetic is modulo 2^ADDR_WIDTH. current_pc+STEP wraps silently with no flag.

## Timing
- All outputs are registered. Their reset values are listed under Operation.
- Next-PC latency is 1 cycle: a select applied in cycle N appears on current_pc after edge N.
- RAS top-of-stack is read combinationally, so RET resolves in the same cycle with no bubble.
- Push and pop never coincide, because pc_sel is single-valued.
- An irq entry and any pc_sel in the same cycle resolve to irq entry.
- ERET and irq in the same cycle while in ISR:
  - ERET executes and state returns to RUN.
  - If irq is still high, it is accepted on the following edge, with epc = the ERET target.
- reset asserted mid-ISR or mid-call-chain discards all state on that edge.
- Releasing halt resumes with the held values; no cycle is skipped.

## Structure
- **Package pc_pkg:**
  - pc_sel_e enum (SEQ, BRANCH, JUMP, CALL, RET, ERET).
  - pc_state_e enum (RUN, ISR).
  - Default constants for STEP, RESET_VECTOR and IRQ_VECTOR.
- **Sub-module pc_ras** (parameters RAS_DEPTH, ADDR_WIDTH):
  - Contents: circular storage, top pointer, saturating count, push/pop ports, top output, full/empty outputs.
  - It does not hold the sticky flags; they live in pc_sequencer.

## Test plan
Defaults throughout: ADDR_WIDTH=32, STEP=4, RESET_VECTOR=0, IRQ_VECTOR=0x80, RAS_DEPTH=4.

1. **Reset, sequential, halt:** reset, then 3×SEQ → current_pc 0,4,8,0xC. Hold halt 2 cycles → PC stays 0xC. Next SEQ → 0x10.
2. **Branch/jump:** at PC=0x10:
   - BRANCH, taken=0 → 0x14.
   - BRANCH, taken=1, target=0x200 → 0x200.
   - JUMP, target=0x300 → 0x300.
3. **Call/return and overflow:**
   - 5 CALLs from PC=0x300 with targets 0x1000,0x2000,0x3000,0x4000,0x5000 → ras_count 4, ras_overflow=1.
   - 4 RETs → 0x4004,0x3004,0x2004,0x1004.
   - 5th RET → PC+4, ras_underflow=1.
4. **Interrupt round trip:**
   - At PC=0x40, irq=1 with pc_sel=JUMP → PC=0x80, epc=0x40, in_isr=1.
   - irq held high plus 2×SEQ → PC=0x84, 0x88 (no re-entry).
   - ERET → PC=0x40, in_isr=0.
   - irq still high → next edge PC=0x80.
5. **Wrap:** JUMP to 0xFFFF_FFFC, then SEQ → PC=0x0, no flag set.
6. **Reset mid-ISR:** in ISR with ras_count=2 and both flags set, pulse reset → PC=0, epc=0, in_isr=0, ras_count=0, flags=0.
